// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the 5-stage pipeline.
// Merges per-stage stall requests, branch-redirect flushes and debug
// halt/single-step into the stall vector and flush strobe, and keeps a
// memory-wait watchdog plus stall/flush event counters for bring-up.
// dbg_state exposes the FSM: 0 = RUN, 1 = HALT, 2 = STEP.
module pipeline_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic        halt_req,
    input  logic        step,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        halted,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    state_e          state_q;
    logic            halted_q;
    logic            flush_pend_q, flush_pend_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_timeout_q, mem_timeout_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic [15:0]     flush_cnt_q, flush_cnt_d;
    logic [5:0]      stall_raw;
    logic [5:0]      stall_c;
    logic            flush_c;

    // Combinational stall/flush decode; a flush squashes the wrong-path
    // load-use stall, and outputs stay quiet while reset is asserted.
    always_comb begin
        stall_raw = 6'b000000;
        if (stallreq_mem) begin
            stall_raw = 6'b011111;
        end else if (stallreq_ex) begin
            stall_raw = 6'b001111;
        end else if (stallreq_id) begin
            stall_raw = 6'b000111;
        end
        flush_c = (flush_req | flush_pend_q) & ~stall_raw[3] & (state_q != ST_HALT);
        if (state_q == ST_HALT) begin
            stall_c = 6'b111111;
        end else if (flush_c) begin
            stall_c = 6'b000000;
        end else begin
            stall_c = stall_raw;
        end
        if (!rst_n) begin
            stall_c = 6'b000000;
            flush_c = 1'b0;
        end
    end

    // Next-state for the pending flush, watchdog and event counters.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (flush_c) begin
            flush_pend_d = 1'b0;
        end else if (flush_req) begin
            flush_pend_d = 1'b1;
        end
        wait_cnt_d = '0;
        if (stallreq_mem) begin
            wait_cnt_d = (wait_cnt_q == {TO_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + TO_W'(1);
        end
        mem_timeout_d = mem_timeout_q | (wait_cnt_d >= TO_W'(TIMEOUT));
        stall_cnt_d = stall_cnt_q;
        if ((stall_c != 6'b000000) && (state_q != ST_HALT)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_c) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Debug FSM with registered halted flag; STEP grants one advancing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (step) begin
                        state_q  <= ST_STEP;
                        halted_q <= 1'b0;
                    end else if (!halt_req) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                ST_STEP: begin
                    state_q  <= halt_req ? ST_HALT : ST_RUN;
                    halted_q <= halt_req;
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Pending flush, watchdog and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend_q  <= 1'b0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= 32'd0;
            flush_cnt_q   <= 16'd0;
        end else begin
            flush_pend_q  <= flush_pend_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign stall       = stall_c;
    assign flush       = flush_c;
    assign halted      = halted_q;
    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the controller.
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        flush_req, halt_req, step;
    logic [5:0]  stall;
    logic        flush, halted, mem_timeout;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [1:0]  dbg_state;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .flush_req(flush_req), .halt_req(halt_req), .step(step),
        .stall(stall), .flush(flush), .halted(halted), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // model of the controller
    bit          m_halt, m_step, m_pend, m_tmo;
    int          m_wait;
    logic [31:0] m_scnt;
    logic [15:0] m_fcnt;
    logic [6:0]  exp_q[$];
    logic [5:0]  last_stall;
    logic        last_flush;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_halt = 0; m_step = 0; m_pend = 0; m_tmo = 0;
        m_wait = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic run_cycle(input bit i_id, input bit i_ex, input bit i_mem,
                             input bit i_fr, input bit i_hr, input bit i_st);
        logic [5:0] e_stall;
        bit         e_flush;
        logic [6:0] e;
        @(negedge clk);
        stallreq_id = i_id; stallreq_ex = i_ex; stallreq_mem = i_mem;
        flush_req = i_fr; halt_req = i_hr; step = i_st;
        #1;
        check_val("halted", halted, m_halt);
        check_val("dbg_halt", dbg_state == 2'd1, m_halt);
        check_val("mem_timeout", mem_timeout, m_tmo);
        check_val("stall_cnt", stall_cnt, m_scnt);
        check_val("flush_cnt", flush_cnt, m_fcnt);
        if (m_halt) begin
            e_stall = 6'h3f;
            e_flush = 0;
        end else begin
            e_flush = (i_fr || m_pend) && !(i_mem || i_ex);
            if (e_flush)    e_stall = 6'h00;
            else if (i_mem) e_stall = 6'h1f;
            else if (i_ex)  e_stall = 6'h0f;
            else if (i_id)  e_stall = 6'h07;
            else            e_stall = 6'h00;
        end
        exp_q.push_back({e_flush, e_stall});
        last_stall = stall;
        last_flush = flush;
        e = exp_q.pop_front();
        check_val("stall", stall, e[5:0]);
        check_val("flush", flush, e[6]);
        @(posedge clk);
        if (e_stall != 0 && !m_halt) m_scnt = m_scnt + 1;
        if (e_flush) m_fcnt = m_fcnt + 1;
        if (e_flush)   m_pend = 0;
        else if (i_fr) m_pend = 1;
        m_wait = i_mem ? ((m_wait == 255) ? 255 : m_wait + 1) : 0;
        if (m_wait >= TIMEOUT) m_tmo = 1;
        if (m_halt) begin
            if (i_st) begin
                m_halt = 0; m_step = 1;
            end else if (!i_hr) begin
                m_halt = 0;
            end
        end else begin
            m_step = 0;
            m_halt = i_hr;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        flush_req = 0; halt_req = 0; step = 0;
        reset_model();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int fl_sum;
        bit r_hr;
        rst_n = 0;
        stallreq_id = 1; stallreq_ex = 0; stallreq_mem = 0;
        flush_req = 1; halt_req = 0; step = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_stall", stall, 0);
        check_val("rst_flush", flush, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_tmo", mem_timeout, 0);
        check_val("rst_scnt", stall_cnt, 0);
        check_val("rst_fcnt", flush_cnt, 0);
        @(negedge clk);
        stallreq_id = 0; flush_req = 0;
        rst_n = 1;

        // priority
        run_cycle(1, 1, 1, 0, 0, 0); check_val("prio_all", last_stall, 6'h1f);
        run_cycle(1, 1, 0, 0, 0, 0); check_val("prio_ex", last_stall, 6'h0f);
        run_cycle(1, 0, 0, 0, 0, 0); check_val("prio_id", last_stall, 6'h07);
        run_cycle(0, 0, 0, 0, 0, 0); check_val("prio_none", last_stall, 6'h00);
        #1 check_val("prio_scnt", stall_cnt, 3);

        // flush over load-use
        run_cycle(1, 0, 0, 1, 0, 0);
        check_val("fl_lu_flush", last_flush, 1);
        check_val("fl_lu_stall", last_stall, 0);
        #1 check_val("fl_lu_fcnt", flush_cnt, 1);

        // deferred flush behind an EX stall
        fl_sum = 0;
        run_cycle(0, 1, 0, 1, 0, 0); fl_sum += last_flush;
        repeat (3) begin
            run_cycle(0, 1, 0, 0, 0, 0); fl_sum += last_flush;
        end
        run_cycle(0, 0, 0, 0, 0, 0); fl_sum += last_flush;
        check_val("defer_flush", last_flush, 1);
        check_val("defer_stall", last_stall, 0);
        run_cycle(0, 0, 0, 0, 0, 0); fl_sum += last_flush;
        check_val("defer_once", fl_sum, 1);

        // halt / step
        run_cycle(0, 0, 0, 0, 1, 0);
        #1 check_val("halt_flag", halted, 1);
        run_cycle(0, 0, 0, 0, 1, 0); check_val("halt_stall", last_stall, 6'h3f);
        run_cycle(0, 0, 0, 0, 1, 1); check_val("step_req", last_stall, 6'h3f);
        run_cycle(1, 0, 0, 0, 1, 0); check_val("step_cycle", last_stall, 6'h07);
        run_cycle(0, 0, 0, 0, 1, 0); check_val("rehalt", last_stall, 6'h3f);
        run_cycle(0, 0, 0, 0, 0, 0);
        #1 check_val("unhalt", halted, 0);
        check_val("halt_scnt", stall_cnt, 8);
        run_cycle(0, 0, 0, 0, 0, 1); check_val("step_ignored", last_stall, 0);

        // watchdog
        repeat (3) run_cycle(0, 0, 1, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0);
        #1 check_val("wd_short", mem_timeout, 0);
        repeat (4) run_cycle(0, 0, 1, 0, 0, 0);
        repeat (2) run_cycle(0, 0, 0, 0, 0, 0);
        #1 check_val("wd_trip", mem_timeout, 1);

        // randomized traffic
        do_reset();
        r_hr = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) r_hr = !r_hr;
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                      r_hr, $urandom_range(0, 3) == 0);
        end

        // async reset mid-halt with a pending flush
        run_cycle(0, 0, 0, 0, 1, 0);
        run_cycle(0, 0, 0, 1, 1, 0);
        #2;
        stallreq_id = 1;
        rst_n = 0;
        #1;
        check_val("arst_stall", stall, 0);
        check_val("arst_flush", flush, 0);
        check_val("arst_halted", halted, 0);
        check_val("arst_scnt", stall_cnt, 0);
        check_val("arst_fcnt", flush_cnt, 0);
        check_val("arst_tmo", mem_timeout, 0);
        reset_model();
        @(negedge clk);
        stallreq_id = 0; halt_req = 0; flush_req = 0;
        rst_n = 1;
        run_cycle(0, 0, 0, 0, 0, 0);
        check_val("arst_no_pend", last_flush, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
